// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
//   Command-side driver for the registered 32-bit ALU. Accepts one request
//   at a time over a valid/ready command port and drives the ALU operand and
//   select registers. It then waits out the ALU result latency (1 edge) and
//   flag latency (2 edges), captures result/flag, and returns them with the
//   request tag over a valid/ready response port.
//
// Ports
//   clk, rst          clock / async active-high reset (shared with ALU)
//   cmd_valid/ready   request handshake; cmd_ready only in IDLE
//   cmd_op/a/b/tag    opcode (0..OP_MAX legal), operands, opaque tag
//   alu_a/b/sel       registered operands / select driven to the ALU
//   alu_y, alu_flag   ALU result (1 edge) and carry flag (2 edges)
//   rsp_valid/ready   response handshake
//   rsp_y/flag/tag    captured result, flag, tag
//   rsp_illegal       request opcode was above OP_MAX
//   busy              FSM not in IDLE
//   done_cnt          completed response handshakes, wraps at 16 bits
module alu_cmd_driver #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter int OP_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_flag,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal,
    output logic             busy,
    output logic [15:0]      done_cnt
);

    localparam logic [3:0] OP_LIM = 4'(OP_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT1 = 3'd2,
        WAIT2 = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             legal;
    logic             capture;
    logic             rsp_hs;
    logic [TAG_W-1:0] tag_q;

    assign legal = (cmd_op <= OP_LIM);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_hs    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    // Illegal ops never reach the ALU; answer next cycle.
                    state_nxt = legal ? ISSUE : RESP;
                end
            end
            ISSUE: state_nxt = WAIT1;
            WAIT1: state_nxt = WAIT2;
            WAIT2: begin
                // Flag is valid now (two edges after operand load).
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operand registers: only legal loads touch them, so they hold
    // between commands and across illegal requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            tag_q   <= '0;
        end else if (accept && legal) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_op;
            tag_q   <= cmd_tag;
        end
    end

    // Response registers: written only on entry to RESP, so they are stable
    // while rsp_valid is high and hold afterwards until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_y       <= '0;
            rsp_flag    <= 1'b0;
            rsp_tag     <= '0;
            rsp_illegal <= 1'b0;
        end else if (accept && !legal) begin
            rsp_y       <= '0;
            rsp_flag    <= 1'b0;
            rsp_tag     <= cmd_tag;
            rsp_illegal <= 1'b1;
        end else if (capture) begin
            rsp_y       <= alu_y;
            rsp_flag    <= alu_flag;
            rsp_tag     <= tag_q;
            rsp_illegal <= 1'b0;
        end
    end

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         done_cnt <= '0;
        else if (rsp_hs) done_cnt <= done_cnt + 16'd1;
    end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side driver for the team's registered 32-bit ALU. It accepts operation requests over a valid/ready command port and drives the ALU's operand and select inputs. It waits out the ALU's register latency and its extra cycle of flag latency, then returns result, flag and tag over a valid/ready response port. It sits between any sequencing master (test sequencer, micro-controller) and the ALU instance, on the same clock and reset.

## Interface
- WIDTH, 32, operand/result width; must equal the ALU datapath width.
- TAG_W, 4, width of the opaque request tag returned with the response.
- OP_MAX, 8, highest legal opcode; codes above it are illegal.

- clk  in  1  rising-edge clock shared with the ALU.
- rst  in  1  asynchronous, active-high reset, shared with the ALU.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  driver can accept a request.
- cmd_op  in  4  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not, 6 shl1, 7 shr1, 8 a<b.
- cmd_a, cmd_b  in  WIDTH  operands.
- cmd_tag  in  TAG_W  request tag.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU a_in/b_in.
- alu_sel  out  4  registered opcode to the ALU select.
- alu_y  in  WIDTH  ALU y_out.
- alu_flag  in  1  ALU flag (carry of a+b, two edges after operands).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_y  out  WIDTH  captured result.
- rsp_flag  out  1  captured flag.
- rsp_tag  out  TAG_W  tag of the request.
- rsp_illegal  out  1  request had opcode > OP_MAX.
- busy  out  1  state is not IDLE.
- done_cnt  out  16  count of completed response handshakes.

## Operation
- FSM states:
  - IDLE: cmd_ready=1.
  - ISSUE, WAIT1, WAIT2: in-flight states.
  - RESP: rsp_valid=1.
- Transitions:
  - IDLE, handshake with legal op: alu_a/alu_b/alu_sel and the tag are loaded, then go to ISSUE.
  - IDLE, handshake with illegal op: go to RESP with rsp_y=0, rsp_flag=0, rsp_illegal=1. alu_* are not updated.
  - ISSUE goes to WAIT1, and WAIT1 goes to WAIT2 unconditionally.
  - WAIT2 goes to RESP. On that edge rsp_y<=alu_y, rsp_flag<=alu_flag, rsp_illegal<=0.
  - RESP: when rsp_valid&&rsp_ready, go to IDLE and done_cnt increments.
- cmd_ready is 1 only in IDLE. No request overlap; one request is outstanding at most.
- alu_a/alu_b/alu_sel hold their value from load until the next legal load, including through IDLE. They do not toggle between commands.
- rsp_flag is the carry-out of the 33-bit sum cmd_a+cmd_b for every opcode, passed through from the ALU unmodified.
- rsp_y/rsp_flag/rsp_tag/rsp_illegal stay stable while rsp_valid=1 and hold their values after the handshake.
- done_cnt wraps from 0xFFFF to 0x0000.
- Reset, any state including mid-operation:
  - State goes to IDLE and the in-flight request is discarded.
  - All outputs become 0, except cmd_ready=1.
  - No response is produced for the discarded request.

## Timing
- Request handshake in cycle C, legal op: ISSUE in C+1, WAIT1 in C+2, WAIT2 in C+3, rsp_valid first high in C+4.
- Illegal op: rsp_valid first high in C+1.
- Response handshake in cycle R: cmd_ready is high in R+1. The minimum legal-op issue interval is 5 cycles.
- rsp_valid stays asserted indefinitely until rsp_ready is high; there is no timeout.
- cmd_valid outside IDLE is ignored. The master holds its request until cmd_ready.
- Reset is asynchronous: outputs take their reset values immediately on rst rising, not at the next clk edge. First accept is possible in the first cycle after rst deasserts.

## Test plan
- Add: op 0, a=5, b=7, tag=3, handshake in cycle C. Required: rsp_valid first high in C+4 with rsp_y=12, rsp_flag=0, rsp_tag=3, rsp_illegal=0.
- Carry: op 0, a=0xFFFFFFFF, b=1. Required: rsp_y=0, rsp_flag=1. Then op 2, a=b=0x80000000. Required: rsp_y=0x80000000, rsp_flag=1, showing the flag is independent of the opcode.
- Compare/shift: op 8, a=2, b=3 gives rsp_y=1, rsp_flag=0. op 6, a=0x80000001 gives rsp_y=0x00000002.
- Illegal: op 0xC, tag=9. Required: rsp_valid in C+1, rsp_illegal=1, rsp_y=0, rsp_flag=0, alu_a/alu_b/alu_sel unchanged from the prior request.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP while cmd_valid=1. Required: response outputs stable, cmd_ready=0, no new request accepted. After rsp_ready=1 for one cycle, done_cnt increments by 1 and cmd_ready=1 in the next cycle.
- Reset mid-op: assert rst during WAIT1. Required: outputs immediately 0 and cmd_ready=1, no response after release, done_cnt=0. A following add (1+1) completes normally with rsp_y=2.
